// File: rtl/bram_arbiter_if.sv
// Signal bundle between bram_arbiter, its two requesters/clear controller and the BRAM.
// master = user logic plus BRAM side, slave = the arbiter itself.
interface bram_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              clr_start;
  logic              clr_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output clr_start,
    input  clr_busy,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  clr_start,
    output clr_busy,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// Two-requester access controller for a 32x4 read-first BRAM with a sequenced full clear.
// Define BRAM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module bram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input logic          clk,
  input logic          rst,
  bram_arbiter_if.slave bus
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [1:0]        rsp_sel, rsp_sel_nxt;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              clr_busy;

`ifdef BRAM_ARB_RR_EN
  logic last;

  // Requester granted most recently; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (ready[0]) begin
      last <= 1'b0;
    end else if (ready[1]) begin
      last <= 1'b1;
    end
  end
`endif

  always_comb begin
    grant = 2'b00;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef BRAM_ARB_RR_EN
      grant = last ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end else if (bus.req0_valid) begin
      grant = 2'b01;
    end else if (bus.req1_valid) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      clr_cnt <= '0;
      rsp_sel <= 2'b00;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rsp_sel <= rsp_sel_nxt;
    end
  end

  // Grants are suppressed while rst is high because ready is a combinational output.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    rsp_sel_nxt = 2'b00;
    ready       = 2'b00;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    clr_busy    = 1'b0;
    case (state)
      ARB: begin
        if (rst) begin
          state_nxt = ARB;
        end else if (bus.clr_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end else begin
          ready       = grant;
          rsp_sel_nxt = grant;
          if (grant[0]) begin
            mem_we    = bus.req0_we;
            mem_addr  = bus.req0_addr;
            mem_wdata = bus.req0_wdata;
          end else if (grant[1]) begin
            mem_we    = bus.req1_we;
            mem_addr  = bus.req1_addr;
            mem_wdata = bus.req1_wdata;
          end
        end
      end
      CLEAR: begin
        mem_we      = 1'b1;
        mem_addr    = clr_cnt;
        clr_busy    = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == {ADDR_W{1'b1}}) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.clr_busy   = clr_busy;
  assign bus.rsp0_valid = rsp_sel[0];
  assign bus.rsp1_valid = rsp_sel[1];
  assign bus.rsp0_rdata = rsp_sel[0] ? bus.mem_rdata : '0;
  assign bus.rsp1_rdata = rsp_sel[1] ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural 32x4 read-first BRAM.
// Expected tie-break order follows BRAM_ARB_RR_EN when it is defined.
module tb_bram_arbiter;

  logic clk;
  logic rst;
  logic preload;
  logic [3:0] mem [32];
  int checks;
  int errors;
  bit rr;

  bram_arbiter_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  bram_arbiter #(.ADDR_W(5), .DATA_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM: r_data registers the old word even when writing.
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic applyStimulus(input logic v0, input logic we0, input logic [4:0] a0,
                               input logic [3:0] d0, input logic v1, input logic we1,
                               input logic [4:0] a1, input logic [3:0] d1, input logic clr);
    @(posedge clk);
    #1;
    bus.req0_valid = v0;
    bus.req0_we    = we0;
    bus.req0_addr  = a0;
    bus.req0_wdata = d0;
    bus.req1_valid = v1;
    bus.req1_we    = we1;
    bus.req1_addr  = a1;
    bus.req1_wdata = d1;
    bus.clr_start  = clr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef BRAM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst            = 1'b1;
    preload        = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_we    = 1'b0;
    bus.req0_addr  = 5'd5;
    bus.req0_wdata = 4'h0;
    bus.req1_valid = 1'b1;
    bus.req1_we    = 1'b0;
    bus.req1_addr  = 5'd9;
    bus.req1_wdata = 4'h0;
    bus.clr_start  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready0", bus.req0_ready, 0);
    checkOutput("rst_ready1", bus.req1_ready, 0);
    checkOutput("rst_rsp0_valid", bus.rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("rst_rsp0_rdata", bus.rsp0_rdata, 0);
    checkOutput("rst_rsp1_rdata", bus.rsp1_rdata, 0);
    checkOutput("rst_clr_busy", bus.clr_busy, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);

    // First tie after reset goes to requester 0 in both configurations.
    rst     = 1'b0;
    preload = 1'b0;
    #1;
    checkOutput("first_tie_ready0", bus.req0_ready, 1);
    checkOutput("first_tie_ready1", bus.req1_ready, 0);
    checkOutput("first_tie_addr", bus.mem_addr, 5);

    applyStimulus(1, 0, 5'd3, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("r0_ready", bus.req0_ready, 1);
    checkOutput("r0_mem_addr", bus.mem_addr, 3);
    checkOutput("r0_mem_we", bus.mem_we, 0);
    checkOutput("tie_rsp0_rdata", bus.rsp0_rdata, 5);

    applyStimulus(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("r0_rsp0_valid", bus.rsp0_valid, 1);
    checkOutput("r0_rsp0_rdata", bus.rsp0_rdata, 3);
    checkOutput("r0_rsp1_valid", bus.rsp1_valid, 0);
    checkOutput("r0_rsp1_rdata", bus.rsp1_rdata, 0);
    checkOutput("idle_ready0", bus.req0_ready, 0);

    applyStimulus(0, 0, 5'd0, 4'h0, 1, 1, 5'd7, 4'hA, 0);
    checkOutput("w1_ready1", bus.req1_ready, 1);
    checkOutput("w1_mem_we", bus.mem_we, 1);
    checkOutput("w1_mem_addr", bus.mem_addr, 7);
    checkOutput("w1_mem_wdata", bus.mem_wdata, 8'hA);
    checkOutput("w1_rsp0_valid", bus.rsp0_valid, 0);

    applyStimulus(0, 0, 5'd0, 4'h0, 1, 0, 5'd7, 4'h0, 0);
    checkOutput("w1_rsp1_valid", bus.rsp1_valid, 1);
    checkOutput("w1_rsp1_old", bus.rsp1_rdata, 7);

    applyStimulus(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("rd1_rsp1_valid", bus.rsp1_valid, 1);
    checkOutput("rd1_rsp1_new", bus.rsp1_rdata, 8'hA);

    // Continuous tie: last grant was requester 1, so round-robin starts with 0.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 5'd1, 4'h0, 1, 0, 5'd2, 4'h0, 0);
      checkOutput("tie_ready0", bus.req0_ready, (rr && (k % 2 == 1)) ? 8'd0 : 8'd1);
      checkOutput("tie_ready1", bus.req1_ready, (rr && (k % 2 == 1)) ? 8'd1 : 8'd0);
    end

    applyStimulus(1, 0, 5'd1, 4'h0, 1, 0, 5'd2, 4'h0, 1);
    checkOutput("clr_c_ready0", bus.req0_ready, 0);
    checkOutput("clr_c_ready1", bus.req1_ready, 0);
    checkOutput("clr_c_busy", bus.clr_busy, 0);
    checkOutput("clr_c_mem_we", bus.mem_we, 0);
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1, 0, 5'd1, 4'h0, 1, 0, 5'd2, 4'h0, 0);
      checkOutput("clr_busy", bus.clr_busy, 1);
      checkOutput("clr_ready0", bus.req0_ready, 0);
      checkOutput("clr_ready1", bus.req1_ready, 0);
      checkOutput("clr_mem_we", bus.mem_we, 1);
      checkOutput("clr_mem_addr", bus.mem_addr, 8'(k));
      checkOutput("clr_mem_wdata", bus.mem_wdata, 0);
      checkOutput("clr_rsp0_valid", bus.rsp0_valid, 0);
    end

    applyStimulus(1, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("post_clr_busy", bus.clr_busy, 0);
    checkOutput("post_clr_ready0", bus.req0_ready, 1);
    checkOutput("post_clr_mem_we", bus.mem_we, 0);
    applyStimulus(0, 0, 5'd0, 4'h0, 1, 0, 5'd17, 4'h0, 0);
    checkOutput("post_clr_ready1", bus.req1_ready, 1);
    checkOutput("clr_a0_valid", bus.rsp0_valid, 1);
    checkOutput("clr_a0_rdata", bus.rsp0_rdata, 0);
    applyStimulus(1, 0, 5'd31, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("clr_a17_valid", bus.rsp1_valid, 1);
    checkOutput("clr_a17_rdata", bus.rsp1_rdata, 0);
    applyStimulus(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("clr_a31_valid", bus.rsp0_valid, 1);
    checkOutput("clr_a31_rdata", bus.rsp0_rdata, 0);

    @(posedge clk);
    #1 preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;

    // Reset in the middle of a clear, with requester 0 waiting on addr 20.
    applyStimulus(1, 0, 5'd20, 4'h0, 0, 0, 5'd0, 4'h0, 1);
    checkOutput("clr2_c_ready0", bus.req0_ready, 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, 5'd20, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    end
    checkOutput("clr2_busy", bus.clr_busy, 1);
    checkOutput("clr2_addr", bus.mem_addr, 9);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", bus.clr_busy, 0);
    checkOutput("midrst_ready0", bus.req0_ready, 0);
    checkOutput("midrst_rsp0_valid", bus.rsp0_valid, 0);
    checkOutput("midrst_mem_we", bus.mem_we, 0);
    checkOutput("midrst_mem_addr", bus.mem_addr, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 5'd20, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("midrst_rd_ready0", bus.req0_ready, 1);
    checkOutput("midrst_rd_addr", bus.mem_addr, 20);
    applyStimulus(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    checkOutput("midrst_rsp0_valid2", bus.rsp0_valid, 1);
    checkOutput("midrst_rsp0_rdata", bus.rsp0_rdata, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester access controller for the 32x4 single-port read-first block RAM. Arbitrates per-cycle access between requester 0 and requester 1 with valid/ready handshakes, returns read data (old contents, read-first) one cycle after acceptance, and provides a sequenced clear that writes zero to all 32 words. Sits between the user logic and the BRAM instance; it is the only driver of the BRAM's `we`/`addr`/`w_data` inputs.

## Interface
- `ADDR_W`, 5, BRAM address width; depth = 2^ADDR_W = 32
- `DATA_W`, 4, BRAM word width
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&ready
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  ADDR_W  word address
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle pulse, response for that requester
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_W  word contents before the access (read-first)
- `clr_start`  in  1  request full-memory clear (pulse or level)
- `clr_busy`  out  1  clear sequence in progress
- `mem_we`  out  1  to BRAM `we`
- `mem_addr`  out  ADDR_W  to BRAM `addr`
- `mem_wdata`  out  DATA_W  to BRAM `w_data`
- `mem_rdata`  in  DATA_W  from BRAM `r_data` (registered in BRAM, valid cycle after address)

## Operation
- States: ARB, CLEAR. Reset state ARB.
- ARB: one grant per cycle max. `reqN_ready` = combinational grant; `mem_*` driven combinationally from granted requester. No grant → `mem_we`=0, `mem_addr`/`mem_wdata` = 0.
- Grant: only one valid → that one. Both valid → see Configuration. Register `last` records last granted requester; reset value 1 (so requester 0 wins first tie).
- `clr_start`=1 in ARB: no grant that cycle (both ready=0), next state CLEAR, counter ← 0.
- CLEAR: `mem_we`=1, `mem_addr`=counter, `mem_wdata`=0, both ready=0, `clr_busy`=1; counter increments each cycle. After counter=31 write, next state ARB, `clr_busy` drops. `clr_start` ignored in CLEAR; held high on return → new clear starts (no grant that cycle).
- Response: registered tag `rsp_sel[1:0]` (one-hot, 0 for clear writes and idle). `rspN_valid` = `rsp_sel[N]`; `rspN_rdata` = `mem_rdata` when `rsp_sel[N]`, else 0. Writes also respond (old data). No response backpressure.
- Reset mid-CLEAR: state ARB, counter 0, `clr_busy` 0; memory contents partially cleared, unspecified.

## Timing
- Accept in cycle T → BRAM access at edge ending T → `rspN_valid`=1, `rspN_rdata` valid in T+1. Latency 1, throughput 1 access/cycle total.
- Back-to-back same address: write in T, read in T+1 → read response in T+2 returns written data.
- Clear: `clr_start` in cycle C → writes in C+1..C+32, `clr_busy` high C+1..C+32, first grant possible C+33.
- Reset values: `req0/1_ready`=0 (forced while `rst`), `rsp0/1_valid`=0, `rsp0/1_rdata`=0, `clr_busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `reqN_valid` may drop without acceptance; no ordering obligation on requesters.

## Configuration
- `BRAM_ARB_RR_EN` defined: tie → requester ≠ `last` wins (round-robin); `last` updated on every grant.
- Not defined: tie → requester 0 always wins (fixed priority); `last` register omitted.

## Test plan
- Memory preloaded 0x0..0xF repeating; req0 reads addr 3 alone → req0_ready=1 in T, rsp0_valid=1 with rdata 0x3 in T+1, rsp1_valid=0.
- req1 write addr 7 data 0xA in T, read addr 7 in T+1 → T+1 rsp1_rdata=0x7 (old), T+2 rsp1_rdata=0xA.
- Both valid continuously, distinct addrs, RR_EN defined → grants 0,1,0,1…; undefined → req0 every cycle, req1_ready stays 0.
- clr_start pulse while both requesting → no grants for 33 cycles (C..C+32), clr_busy 32 cycles, then reads of addrs 0, 17, 31 return 0x0.
- rst asserted at clear cycle 10 → clr_busy, ready, rsp_valid 0 immediately; after release req0 read addr 20 returns preload 0x4.
- Reset release: first tie grants requester 0 in both configurations.
